// File: rtl/edge_pkg.sv
// Shared types for the edge frame arbiter: pixel formats, input FSM states,
// frame-owner tag and the frame size helper.
package edge_pkg;

    typedef logic [23:0] pixel_rgb_t;
    typedef logic [7:0]  pixel_gray_t;
    typedef logic [0:0]  owner_t;

    typedef enum logic {
        IDLE,
        STREAM
    } in_state_t;

    function automatic int pixel_count(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/owner_tag_fifo.sv
// Small FWFT queue of frame owners carried across the edge_detect latency.
// Ports: clock/reset, push + push_owner, pop, full/empty, head (oldest tag).
module owner_tag_fifo
    import edge_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   push,
    input  owner_t push_owner,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output owner_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    owner_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_owner;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/edge_frame_arbiter.sv
// Shares one edge_detect between two FWFT pixel sources, one frame at a time.
// Ports: src0/src1 FIFO side, ed_in/ed_out edge_detect side, dst0/dst1 consumers.
module edge_frame_arbiter
    import edge_pkg::*;
#(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int TAG_DEPTH  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        src0_empty,
    output logic        src0_rd_en,
    input  pixel_rgb_t  src0_dout,
    input  logic        src1_empty,
    output logic        src1_rd_en,
    input  pixel_rgb_t  src1_dout,
    input  logic        ed_in_full,
    output logic        ed_in_wr_en,
    output pixel_rgb_t  ed_in_din,
    input  logic        ed_out_empty,
    output logic        ed_out_rd_en,
    input  pixel_gray_t ed_out_dout,
    output logic        dst0_empty,
    input  logic        dst0_rd_en,
    output logic        dst1_empty,
    input  logic        dst1_rd_en,
    output pixel_gray_t dst_dout,
    output owner_t      in_owner,
    output logic        in_busy
);

    localparam int PIXELS = pixel_count(IMG_WIDTH, IMG_HEIGHT);
    localparam int CNT_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PIXELS - 1);

    in_state_t        state_q;
    in_state_t        state_d;
    owner_t           owner_q;
    owner_t           owner_d;
    owner_t           last_q;
    owner_t           last_d;
    logic [CNT_W-1:0] in_cnt_q;
    logic [CNT_W-1:0] in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q;
    logic [CNT_W-1:0] out_cnt_d;

    logic   req0;
    logic   req1;
    logic   own_empty;
    logic   xfer;
    logic   tag_push;
    logic   tag_pop;
    logic   tag_full;
    logic   tag_empty;
    owner_t tag_head;

    assign req0      = !src0_empty;
    assign req1      = !src1_empty;
    assign own_empty = owner_q[0] ? src1_empty : src0_empty;

    // Grant is gated on tag space so a push never meets a full queue.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        in_cnt_d = in_cnt_q;
        tag_push = 1'b0;
        xfer     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!tag_full && (req0 || req1)) begin
                    owner_d  = (req0 && req1) ? ~last_q : owner_t'(req1);
                    last_d   = owner_d;
                    tag_push = 1'b1;
                    in_cnt_d = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                xfer = !own_empty && !ed_in_full;
                if (xfer) begin
                    if (in_cnt_q == LAST) begin
                        state_d = IDLE;
                    end else begin
                        in_cnt_d = in_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign src0_rd_en  = !reset && xfer && !owner_q[0];
    assign src1_rd_en  = !reset && xfer && owner_q[0];
    assign ed_in_wr_en = !reset && xfer;
    assign ed_in_din   = owner_q[0] ? src1_dout : src0_dout;
    assign in_busy     = !reset && (state_q == STREAM);
    assign in_owner    = reset ? owner_t'(0) : owner_q;

    // Output routing follows the oldest tag; the other consumer sees empty.
    always_comb begin
        dst0_empty   = 1'b1;
        dst1_empty   = 1'b1;
        ed_out_rd_en = 1'b0;
        out_cnt_d    = out_cnt_q;
        tag_pop      = 1'b0;
        if (!reset && !tag_empty) begin
            unique case (1'b1)
                !tag_head[0]: begin
                    dst0_empty   = ed_out_empty;
                    ed_out_rd_en = dst0_rd_en && !ed_out_empty;
                end
                tag_head[0]: begin
                    dst1_empty   = ed_out_empty;
                    ed_out_rd_en = dst1_rd_en && !ed_out_empty;
                end
                default: ed_out_rd_en = 1'b0;
            endcase
            if (ed_out_rd_en) begin
                if (out_cnt_q == LAST) begin
                    out_cnt_d = '0;
                    tag_pop   = 1'b1;
                end else begin
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign dst_dout = ed_out_dout;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= 1'b1;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    owner_tag_fifo #(
        .DEPTH(TAG_DEPTH)
    ) u_tags (
        .clock      (clock),
        .reset      (reset),
        .push       (tag_push),
        .push_owner (owner_d),
        .pop        (tag_pop),
        .full       (tag_full),
        .empty      (tag_empty),
        .head       (tag_head)
    );

    // An edge pixel with no frame in flight has no owner to go to.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(tag_empty && !ed_out_empty));
        end
    end

endmodule

// File: tb/tb_edge_frame_arbiter.sv
// Scoreboard bench: FIFO models for sources and edge_detect, per-consumer expected queues.
module tb_edge_frame_arbiter;
    import edge_pkg::*;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int P   = 8;
    localparam int TD  = 2;
    localparam int LAT = 5;

    typedef struct {
        logic [7:0] g;
        bit         src;
        int         t;
    } ed_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        src0_empty, src0_rd_en, src1_empty, src1_rd_en;
    logic [23:0] src0_dout, src1_dout, ed_in_din;
    logic        ed_in_full = 1'b0;
    logic        ed_in_wr_en, ed_out_empty, ed_out_rd_en;
    logic [7:0]  ed_out_dout, dst_dout;
    logic        dst0_empty, dst0_rd_en, dst1_empty, dst1_rd_en;
    owner_t      in_owner;
    logic        in_busy;

    always #5 clock = ~clock;

    edge_frame_arbiter #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .TAG_DEPTH(TD)
    ) dut (
        .clock(clock), .reset(reset),
        .src0_empty(src0_empty), .src0_rd_en(src0_rd_en), .src0_dout(src0_dout),
        .src1_empty(src1_empty), .src1_rd_en(src1_rd_en), .src1_dout(src1_dout),
        .ed_in_full(ed_in_full), .ed_in_wr_en(ed_in_wr_en), .ed_in_din(ed_in_din),
        .ed_out_empty(ed_out_empty), .ed_out_rd_en(ed_out_rd_en),
        .ed_out_dout(ed_out_dout),
        .dst0_empty(dst0_empty), .dst0_rd_en(dst0_rd_en),
        .dst1_empty(dst1_empty), .dst1_rd_en(dst1_rd_en),
        .dst_dout(dst_dout), .in_owner(in_owner), .in_busy(in_busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int m0 = 0;
    int m1 = 0;
    int fall0 = 0;
    int pops0 = 0;
    int pops1 = 0;
    int ordn_cnt = 0;
    bit d1_seen = 0;

    logic [23:0] sq0[$];
    logic [23:0] sq1[$];
    logic [7:0]  exp0[$];
    logic [7:0]  exp1[$];
    ed_t         edq[$];
    int          wr_cyc[$];
    bit          wr_src[$];
    int          pop_cyc[$];
    bit          pop_src[$];
    bit          grants[$];
    int          gcyc[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [7:0] gray(input logic [23:0] p);
        return p[7:0] ^ p[15:8] ^ p[23:16];
    endfunction

    function automatic bit avail();
        if (edq.size() == 0) return 1'b0;
        return edq[0].t <= cyc;
    endfunction

    function automatic logic rd_mode(input int m);
        if (m == 2) return 1'b1;
        if (m == 1) return 1'($urandom % 2);
        return 1'b0;
    endfunction

    task automatic drive();
        bit a;
        src0_empty = (sq0.size() == 0);
        src0_dout  = src0_empty ? 24'h0 : sq0[0];
        src1_empty = (sq1.size() == 0);
        src1_dout  = src1_empty ? 24'h0 : sq1[0];
        a = avail();
        ed_out_empty = !a;
        ed_out_dout  = a ? edq[0].g : 8'h0;
        dst0_rd_en = rd_mode(m0);
        dst1_rd_en = rd_mode(m1);
    endtask

    // Source FIFOs and a fixed-latency edge_detect stand-in.
    initial begin : model
        bit s_rd0, s_rd1, s_wr, s_ordn, s_rst, s_full;
        bit s_d0e, s_d1e, s_r0, s_r1, s_busy, prev_busy, prev_e0, own;
        logic [23:0] s_din, dump;
        ed_t e;
        prev_busy = 0;
        prev_e0 = 1;
        drive();
        forever begin
            @(negedge clock);
            s_rd0 = src0_rd_en; s_rd1 = src1_rd_en; s_wr = ed_in_wr_en;
            s_din = ed_in_din; s_ordn = ed_out_rd_en; s_rst = reset;
            s_full = ed_in_full; s_d0e = dst0_empty; s_d1e = dst1_empty;
            s_r0 = dst0_rd_en; s_r1 = dst1_rd_en; s_busy = in_busy;
            if (!s_rst) begin
                chk("rd_exclusive", 32'(s_rd0 & s_rd1), 0);
                chk("wr_follows_rd", 32'(s_wr), 32'(s_rd0 | s_rd1));
                if (s_wr) begin
                    chk("wr_while_full", 32'(s_full), 0);
                    wr_cyc.push_back(cyc);
                    wr_src.push_back(s_rd1);
                    if (s_rd1) begin
                        if (sq1.size() == 0) fail("pop_src1_empty");
                        else chk("in_din_src1", s_din, sq1[0]);
                    end else if (s_rd0) begin
                        if (sq0.size() == 0) fail("pop_src0_empty");
                        else chk("in_din_src0", s_din, sq0[0]);
                    end
                end
                if (!avail()) begin
                    chk("dst0_empty_idle", 32'(s_d0e), 1);
                    chk("dst1_empty_idle", 32'(s_d1e), 1);
                    chk("out_rd_idle", 32'(s_ordn), 0);
                end else begin
                    own = edq[0].src;
                    chk("dst_empty_owner", 32'(own ? s_d1e : s_d0e), 0);
                    chk("dst_empty_other", 32'(own ? s_d0e : s_d1e), 1);
                    chk("out_rd_route", 32'(s_ordn), 32'(own ? s_r1 : s_r0));
                end
                if (s_ordn) ordn_cnt++;
                if (!s_d1e) d1_seen = 1;
                if (prev_e0 && !src0_empty) fall0 = cyc;
                if (s_busy && !prev_busy) begin
                    grants.push_back(in_owner[0]);
                    gcyc.push_back(cyc);
                end
                prev_busy = s_busy;
            end else begin
                prev_busy = 0;
            end
            prev_e0 = src0_empty;
            @(posedge clock);
            #1;
            cyc++;
            if (reset) begin
                sq0.delete(); sq1.delete(); edq.delete();
            end else if (!s_rst) begin
                if (s_rd0 && sq0.size() > 0) dump = sq0.pop_front();
                if (s_rd1 && sq1.size() > 0) dump = sq1.pop_front();
                if (s_ordn && edq.size() > 0) e = edq.pop_front();
                if (s_wr) begin
                    e.g = gray(s_din); e.src = s_rd1; e.t = cyc + LAT - 1;
                    edq.push_back(e);
                end
            end
            drive();
        end
    end

    // Consumer-side scoreboard.
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (reset === 1'b0) begin
                if (!dst0_empty && dst0_rd_en) begin
                    pops0++; pop_cyc.push_back(cyc); pop_src.push_back(0);
                    if (exp0.size() == 0) fail("dst0_unexpected");
                    else chk("dst0_data", dst_dout, exp0.pop_front());
                end
                if (!dst1_empty && dst1_rd_en) begin
                    pops1++; pop_cyc.push_back(cyc); pop_src.push_back(1);
                    if (exp1.size() == 0) fail("dst1_unexpected");
                    else chk("dst1_data", dst_dout, exp1.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic load_frame(input int s, input bit seq);
        logic [23:0] p;
        for (int i = 0; i < P; i++) begin
            p = seq ? 24'(i + 1) : 24'($urandom);
            if (s == 0) begin sq0.push_back(p); exp0.push_back(gray(p)); end
            else begin sq1.push_back(p); exp1.push_back(gray(p)); end
        end
    endtask

    task automatic clear_logs();
        wr_cyc.delete(); wr_src.delete(); pop_cyc.delete(); pop_src.delete();
        grants.delete(); gcyc.delete();
        pops0 = 0; pops1 = 0; d1_seen = 0; ordn_cnt = 0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (sq0.size() == 0 && sq1.size() == 0 && edq.size() == 0 &&
                exp0.size() == 0 && exp1.size() == 0 && !in_busy) break;
            step(1);
        end
        if (i == budget) fail("drain_timeout");
    endtask

    task automatic wait_wr(input int n, input int budget);
        for (int i = 0; i < budget && wr_cyc.size() < n; i++) step(1);
        if (wr_cyc.size() < n) fail("wr_timeout");
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        exp0.delete(); exp1.delete();
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    initial begin : stim
        int k, n0;
        step(1);
        chk("rst_src0_rd", 32'(src0_rd_en), 0);
        chk("rst_src1_rd", 32'(src1_rd_en), 0);
        chk("rst_wr", 32'(ed_in_wr_en), 0);
        chk("rst_out_rd", 32'(ed_out_rd_en), 0);
        chk("rst_dst_empty", 32'({dst0_empty, dst1_empty}), 3);
        chk("rst_busy", 32'(in_busy), 0);
        chk("rst_owner", 32'(in_owner), 0);
        step(1);
        reset = 1'b0;
        step(2);
        chk("post_rst_busy", 32'(in_busy), 0);

        // 1: source 0 alone, sequential pixels
        clear_logs();
        m0 = 1; m1 = 1;
        load_frame(0, 1);
        wait_drain(200);
        chk("t1_wr_count", wr_cyc.size(), 8);
        if (wr_cyc.size() >= 8) begin
            chk("t1_first_wr", wr_cyc[0], fall0 + 1);
            chk("t1_last_wr", wr_cyc[7], fall0 + 8);
        end
        chk("t1_dst0_pops", pops0, 8);
        chk("t1_dst1_pops", pops1, 0);
        chk("t1_dst1_empty_held", 32'(d1_seen), 0);

        // 2: tie after reset, consumer 1 always requesting
        pulse_reset();
        clear_logs();
        m0 = 1; m1 = 2;
        load_frame(0, 0);
        load_frame(1, 0);
        wait_drain(300);
        chk("t2_grants", grants.size(), 2);
        if (grants.size() == 2) begin
            chk("t2_first_owner", 32'(grants[0]), 0);
            chk("t2_second_owner", 32'(grants[1]), 1);
        end
        n0 = 0;
        for (int i = 0; i < 8 && i < wr_src.size(); i++) n0 += (wr_src[i] == 0);
        chk("t2_src0_first", n0, 8);
        n0 = 0;
        for (int i = 0; i < 8 && i < pop_src.size(); i++) n0 += (pop_src[i] == 0);
        chk("t2_dst0_first", n0, 8);
        chk("t2_dst0_pops", pops0, 8);
        chk("t2_dst1_pops", pops1, 8);

        // 3: stall ed_in_full for 3 cycles after pixel 4
        clear_logs();
        m0 = 1; m1 = 1;
        load_frame(0, 0);
        wait_wr(4, 50);
        k = cyc;
        ed_in_full = 1'b1;
        step(3);
        chk("t3_no_wr_in_stall", wr_cyc.size(), 4);
        ed_in_full = 1'b0;
        wait_drain(200);
        chk("t3_wr_count", wr_cyc.size(), 8);
        if (wr_cyc.size() >= 5) chk("t3_pixel5_cycle", wr_cyc[4], k + 3);
        chk("t3_dst0_pops", pops0, 8);

        // 4: output stalled, tag queue limits frames in flight
        clear_logs();
        m0 = 0; m1 = 0;
        for (int i = 0; i < 4; i++) begin
            load_frame(0, 0);
            load_frame(1, 0);
        end
        step(40);
        chk("t4_grants_held", grants.size(), TD);
        chk("t4_idle", 32'(in_busy), 0);
        chk("t4_src_left", sq0.size() + sq1.size(), 48);
        pop_cyc.delete(); pop_src.delete();
        m0 = 2; m1 = 2;
        wait_drain(600);
        chk("t4_grants_total", grants.size(), 8);
        if (gcyc.size() >= 3 && pop_cyc.size() >= 8)
            chk("t4_third_grant", gcyc[2], pop_cyc[7] + 2);
        else
            fail("t4_third_grant_missing");

        // 5: wrong consumer asks while source 0 owns the output
        clear_logs();
        m0 = 0; m1 = 2;
        load_frame(0, 0);
        step(25);
        chk("t5_no_out_rd", ordn_cnt, 0);
        chk("t5_data_held", exp0.size(), 8);
        m0 = 1;
        wait_drain(200);
        chk("t5_dst0_pops", pops0, 8);
        chk("t5_dst1_pops", pops1, 0);

        // 6: reset mid-frame, then a lone source 1 frame
        clear_logs();
        m0 = 1; m1 = 1;
        load_frame(0, 0);
        wait_wr(3, 50);
        reset = 1'b1;
        exp0.delete(); exp1.delete();
        step(1);
        reset = 1'b0;
        #1;
        chk("t6_src_rd", 32'({src0_rd_en, src1_rd_en}), 0);
        chk("t6_wr", 32'(ed_in_wr_en), 0);
        chk("t6_out_rd", 32'(ed_out_rd_en), 0);
        chk("t6_dst_empty", 32'({dst0_empty, dst1_empty}), 3);
        chk("t6_busy", 32'(in_busy), 0);
        step(1);
        clear_logs();
        load_frame(1, 0);
        wait_drain(200);
        chk("t6_grants", grants.size(), 1);
        if (grants.size() == 1) chk("t6_owner", 32'(grants[0]), 1);
        chk("t6_dst1_pops", pops1, 8);
        chk("t6_dst0_pops", pops0, 0);

        // random traffic
        clear_logs();
        m0 = 1; m1 = 1;
        for (int f = 0; f < 12; f++) begin
            load_frame(int'($urandom % 2), 0);
            repeat ($urandom_range(0, 12)) begin
                ed_in_full = ($urandom % 3 == 0);
                step(1);
            end
        end
        ed_in_full = 1'b0;
        wait_drain(1500);
        chk("rand_total_pops", pops0 + pops1, 96);
        chk("rand_grants", grants.size(), 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
